// File: rtl/jt12_wrseq.sv
// Bus-master write sequencer for the jt12 host port: queues {part,reg,val} commands and
// plays each as address write, data write, then busy polling. Optional: JT12_WRSEQ_TIMEOUT_EN.
module jt12_wrseq #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned WR_CYC     = 2,
  parameter int unsigned GAP_CYC    = 1
`ifdef JT12_WRSEQ_TIMEOUT_EN
  ,
  parameter int unsigned TMO_CYC    = 255
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_part,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_val,
  output logic       cs_n,
  output logic       wr_n,
  output logic [1:0] addr,
  output logic [7:0] din,
  input  logic [7:0] dout,
  output logic       idle,
  output logic       err
);

  localparam int unsigned Depth   = 2 ** DEPTH_LOG2;
  localparam int unsigned MaxWg   = (WR_CYC > GAP_CYC) ? WR_CYC : GAP_CYC;
  localparam int unsigned MaxCyc  = (MaxWg > 2) ? MaxWg : 2;
  localparam int unsigned CntW    = $clog2(MaxCyc);
  localparam logic [CntW-1:0] WrLoad   = CntW'(WR_CYC - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYC - 1);
  // Status is registered inside jt12, so the poll needs two cycles before sampling.
  localparam logic [CntW-1:0] PollLoad = CntW'(1);
  localparam logic [DEPTH_LOG2:0] FullCnt = (DEPTH_LOG2 + 1)'(Depth);

`ifdef JT12_WRSEQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TMO_CYC + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TMO_CYC - 1);
`endif

  typedef struct packed {
    logic       part;
    logic [7:0] rg;
    logic [7:0] val;
  } cmd_t;

  typedef enum logic [2:0] {
    StIdle,
    StAwr,
    StAgap,
    StDwr,
    StDgap,
    StPoll,
    StPgap
  } state_e;

  // FIFO
  cmd_t                  mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  push, pop;
  cmd_t                  head;

  // FSM and registered outputs
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  cmd_t            lat_q, lat_d, cur;
  logic            cs_n_q, cs_n_d;
  logic            wr_n_q, wr_n_d;
  logic [1:0]      addr_q, addr_d;
  logic [7:0]      din_q, din_d;
  logic            cnt_done;

`ifdef JT12_WRSEQ_TIMEOUT_EN
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;
`endif

  logic unused_dout;
  assign unused_dout = ^dout[6:0];

  assign cmd_ready = (count_q != FullCnt);
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem_q[rptr_q];
  assign idle      = (count_q == '0) && (state_q == StIdle);
  assign cnt_done  = (cnt_q == '0);
  // On the IDLE->AWR edge the head is not latched yet, so read it straight from the FIFO.
  assign cur       = (state_q == StIdle) ? head : lat_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= '{part: cmd_part, rg: cmd_reg, val: cmd_val};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_done ? cnt_q : cnt_q - 1'b1;
    pop     = 1'b0;
    lat_d   = lat_q;
`ifdef JT12_WRSEQ_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif

    case (state_q)
      StIdle: begin
        cnt_d = cnt_q;
        if (count_q != '0) begin
          state_d = StAwr;
          cnt_d   = WrLoad;
          pop     = 1'b1;
          lat_d   = head;
`ifdef JT12_WRSEQ_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      StAwr: begin
        if (cnt_done) begin
          state_d = StAgap;
          cnt_d   = GapLoad;
        end
      end
      StAgap: begin
        if (cnt_done) begin
          state_d = StDwr;
          cnt_d   = WrLoad;
        end
      end
      StDwr: begin
        if (cnt_done) begin
          state_d = StDgap;
          cnt_d   = GapLoad;
        end
      end
      StDgap: begin
        if (cnt_done) begin
          state_d = StPoll;
          cnt_d   = PollLoad;
        end
      end
      StPoll: begin
        if (cnt_done) begin
          if (!dout[7]) begin
            state_d = StIdle;
          end else begin
`ifdef JT12_WRSEQ_TIMEOUT_EN
            if (tmo_q == TmoLast) begin
              state_d = StIdle;
              err_d   = 1'b1;
            end else begin
              tmo_d   = tmo_q + 1'b1;
              state_d = StPgap;
              cnt_d   = GapLoad;
            end
`else
            state_d = StPgap;
            cnt_d   = GapLoad;
`endif
          end
        end
      end
      StPgap: begin
        if (cnt_done) begin
          state_d = StPoll;
          cnt_d   = PollLoad;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs follow the next state so every pin is driven straight from a flop.
  always_comb begin
    cs_n_d = 1'b1;
    wr_n_d = 1'b1;
    addr_d = addr_q;
    din_d  = din_q;
    case (state_d)
      StAwr: begin
        cs_n_d = 1'b0;
        wr_n_d = 1'b0;
        addr_d = {cur.part, 1'b0};
        din_d  = cur.rg;
      end
      StDwr: begin
        cs_n_d = 1'b0;
        wr_n_d = 1'b0;
        addr_d = {lat_q.part, 1'b1};
        din_d  = lat_q.val;
      end
      StPoll: begin
        cs_n_d = 1'b0;
        addr_d = 2'd0;
      end
      default: begin
        cs_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lat_q   <= '0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      addr_q  <= 2'd0;
      din_q   <= 8'd0;
`ifdef JT12_WRSEQ_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
`ifdef JT12_WRSEQ_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign cs_n = cs_n_q;
  assign wr_n = wr_n_q;
  assign addr = addr_q;
  assign din  = din_q;
`ifdef JT12_WRSEQ_TIMEOUT_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_jt12_wrseq.sv
// Self-checking bench for jt12_wrseq: a host-port bus monitor decodes strobes into register
// writes and answers status polls from a per-command busy count.
module tb_jt12_wrseq;

  localparam int unsigned DepthLog2 = 2;
  localparam int unsigned Depth     = 4;
  localparam int unsigned WrCyc     = 2;
  localparam int unsigned GapCyc    = 1;
`ifdef JT12_WRSEQ_TIMEOUT_EN
  localparam int TmoLimit = 4;
`else
  localparam int TmoLimit = 1 << 30;
`endif

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_part;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_val;
  logic       cs_n;
  logic       wr_n;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       idle;
  logic       err;

  jt12_wrseq #(
    .DEPTH_LOG2(DepthLog2),
    .WR_CYC    (WrCyc),
    .GAP_CYC   (GapCyc)
`ifdef JT12_WRSEQ_TIMEOUT_EN
    ,
    .TMO_CYC   (4)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_part (cmd_part),
    .cmd_reg  (cmd_reg),
    .cmd_val  (cmd_val),
    .cs_n     (cs_n),
    .wr_n     (wr_n),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .idle     (idle),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [16:0] exp_q [$];
  int          busy_q [$];
  logic [7:0]  exp_regs [512];
  logic [7:0]  obs_regs [512];
  int          n_acc, n_start, n_strobes;
  int          cur_busy, poll_idx;
  bit          have_prev, tmo_seen;

  // Monitor state
  int          wr_len, poll_len;
  logic [1:0]  cap_addr;
  logic [7:0]  cap_din;
  logic        pend_part;
  logic [7:0]  pend_reg;

  int e_cs   [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
  int e_wr   [9] = '{0, 0, 1, 0, 0, 1, 1, 1, 1};
  int e_addr [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
  int e_din  [9] = '{8'h28, 8'h28, 0, 8'hF0, 8'hF0, 0, 0, 0, 0};
  int e_idle [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int exp_polls(input int b);
    return (b + 1 < TmoLimit) ? b + 1 : TmoLimit;
  endfunction

  task automatic decode(input logic [1:0] a, input logic [7:0] d);
    logic [16:0] obs;
    logic [16:0] want;
    if (!a[0]) begin
      pend_part = a[1];
      pend_reg  = d;
    end else begin
      chk("dwr_part", {31'd0, a[1]}, {31'd0, pend_part});
      obs = {a[1], pend_reg, d};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL wr_unexpected: got %0h expected none", obs);
      end else begin
        want = exp_q.pop_front();
        chk("wr_cmd", {15'd0, obs}, {15'd0, want});
      end
      obs_regs[{a[1], pend_reg}] = d;
      if (have_prev) chk("poll_count", poll_idx, exp_polls(cur_busy));
      cur_busy  = (busy_q.size() != 0) ? busy_q.pop_front() : 0;
      if (cur_busy >= TmoLimit) tmo_seen = 1'b1;
      have_prev = 1'b1;
      poll_idx  = 0;
    end
  endtask

  // jt12 host-port model: sampled 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      wr_len = 0; poll_len = 0; n_acc = 0; n_start = 0;
      exp_q.delete(); busy_q.delete();
      have_prev = 1'b0; poll_idx = 0; tmo_seen = 1'b0; dout = 8'h00;
    end else begin
      if (!cs_n && !wr_n) begin
        if (wr_len == 0) begin
          cap_addr = addr;
          cap_din  = din;
          n_strobes++;
          if (!addr[0]) n_start++;
        end else begin
          chk("wr_stable", {22'd0, addr, din}, {22'd0, cap_addr, cap_din});
        end
        wr_len++;
      end else if (wr_len != 0) begin
        chk("wr_len", wr_len, WrCyc);
        wr_len = 0;
        decode(cap_addr, cap_din);
      end
      if (!cs_n && wr_n) begin
        if (poll_len == 0) begin
          chk("poll_addr", {30'd0, addr}, 0);
          poll_idx++;
          dout = {(poll_idx <= cur_busy), 7'($urandom)};
        end
        poll_len++;
      end else if (poll_len != 0) begin
        chk("poll_len", poll_len, 2);
        poll_len = 0;
      end
    end
  end

  task automatic push(input logic p, input logic [7:0] r, input logic [7:0] v,
                      input int busy);
    int waited;
    waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_part  = p;
    cmd_reg   = r;
    cmd_val   = v;
    chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, ((n_acc - n_start) < int'(Depth))});
    while (cmd_ready !== 1'b1) begin
      if (waited == 500) begin
        checks++;
        errors++;
        $error("FAIL push_timeout: got ready=%b expected 1 within 500 cycles", cmd_ready);
        cmd_valid = 1'b0;
        return;
      end
      waited++;
      @(negedge clk);
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, ((n_acc - n_start) < int'(Depth))});
    end
    @(posedge clk);
    exp_q.push_back({p, r, v});
    busy_q.push_back(busy);
    exp_regs[{p, r}] = v;
    n_acc++;
    #1;
    cmd_valid = 1'b0;
    cmd_part  = 1'($urandom);
    cmd_reg   = 8'($urandom);
    cmd_val   = 8'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (idle !== 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_idle"}, {31'd0, idle}, 1);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, tmo_seen});
    if (have_prev) chk({tag, "_polls"}, poll_idx, exp_polls(cur_busy));
    have_prev = 1'b0;
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 512; i++) begin
      chk(tag, {24'd0, obs_regs[i]}, {24'd0, exp_regs[i]});
    end
  endtask

  initial begin
    #2_000_000;
    $error("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    for (int i = 0; i < 512; i++) begin
      exp_regs[i] = 8'h00;
      obs_regs[i] = 8'h00;
    end
    n_strobes = 0;
    dout      = 8'h00;
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_part  = 1'b1;
    cmd_reg   = 8'h5A;
    cmd_val   = 8'hA5;

    // 1: reset with valid asserted
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #2;
      chk("rst_cs_n", {31'd0, cs_n}, 1);
      chk("rst_wr_n", {31'd0, wr_n}, 1);
      chk("rst_addr", {30'd0, addr}, 0);
      chk("rst_din", {24'd0, din}, 0);
      chk("rst_ready", {31'd0, cmd_ready}, 1);
      chk("rst_idle", {31'd0, idle}, 1);
      chk("rst_err", {31'd0, err}, 0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;

    // 2: cycle-exact single write, busy clear on first sample
    push(1'b0, 8'h28, 8'hF0, 0);
    @(negedge clk);
    chk("t2_idle0", {31'd0, idle}, 0);
    chk("t2_cs0", {31'd0, cs_n}, 1);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("t2_cs_n", {31'd0, cs_n}, e_cs[k]);
      chk("t2_wr_n", {31'd0, wr_n}, e_wr[k]);
      chk("t2_idle", {31'd0, idle}, e_idle[k]);
      if (e_cs[k] == 0) chk("t2_addr", {30'd0, addr}, e_addr[k]);
      if (e_wr[k] == 0) chk("t2_din", {24'd0, din}, e_din[k]);
    end
    wait_idle("t2");

    // 3: part II write, busy for three polls
    push(1'b1, 8'h30, 8'h71, 3);
    wait_idle("t3");

    // 4: back-to-back burst overflows the FIFO
    for (int i = 0; i < 6; i++) begin
      push(1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 2));
    end
    wait_idle("t4");

    // randomized traffic with random spacing
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      push(1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
    end
    wait_idle("rnd");
    chk_regs("reg_model");

    // 5: reset during the data write aborts everything queued
    push(1'b0, 8'hB0, 8'h11, 0);
    push(1'b1, 8'hB1, 8'h22, 0);
    snap = 0;
    while (!(cs_n === 1'b0 && wr_n === 1'b0 && addr[0] === 1'b1) && snap < 100) begin
      snap++;
      @(negedge clk);
    end
    chk("t5_reach_dwr", {31'd0, addr[0]}, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk("t5_cs_n", {31'd0, cs_n}, 1);
    chk("t5_wr_n", {31'd0, wr_n}, 1);
    chk("t5_idle", {31'd0, idle}, 1);
    chk("t5_ready", {31'd0, cmd_ready}, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    snap  = n_strobes;
    repeat (30) @(negedge clk);
    chk("t5_no_strobes", n_strobes, snap);
    chk("t5_idle_after", {31'd0, idle}, 1);
    chk("t5_cs_after", {31'd0, cs_n}, 1);

`ifdef JT12_WRSEQ_TIMEOUT_EN
    // 6: stuck busy times out, next command still runs
    push(1'b0, 8'h2A, 8'h55, 1000);
    push(1'b1, 8'hB4, 8'h0C, 0);
    wait_idle("t6");
    chk("t6_err", {31'd0, err}, 1);
`endif
    chk("final_err", {31'd0, err}, {31'd0, tmo_seen});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
